// File: rtl/lut_pkg.sv
// Shared definitions for the branch-target table writer.
// Holds the default table geometry, the "no target" fill value and
// the loader FSM state encoding.
package lut_pkg;

  localparam int LUT_ADDR_W = 4;
  localparam int LUT_TGT_W  = 9;
  localparam int LUT_DEPTH  = 16;

  // All-ones marks an entry that has no branch target.
  localparam logic [LUT_TGT_W-1:0] NO_TARGET = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FILL  = 2'd2,
    READY = 2'd3
  } lut_wr_state_t;

endpackage

// File: rtl/branch_lut_writer_if.sv
// Bus between the branch-target table writer and its producer/reader.
// Ports (slave = writer side):
//   Start   - one-cycle pulse beginning a load
//   InValid/InReady/InData/InLast - target stream handshake
//   Addr/Target - combinational table read
//   Busy/Done/Error - load status
interface branch_lut_writer_if #(
  parameter int ADDR_W = 4,
  parameter int TGT_W  = 9
);
  logic              Start;
  logic              InValid;
  logic              InReady;
  logic [TGT_W-1:0]  InData;
  logic              InLast;
  logic [ADDR_W-1:0] Addr;
  logic [TGT_W-1:0]  Target;
  logic              Busy;
  logic              Done;
  logic              Error;

  modport master (
    output Start, InValid, InData, InLast, Addr,
    input  InReady, Target, Busy, Done, Error
  );

  modport slave (
    input  Start, InValid, InData, InLast, Addr,
    output InReady, Target, Busy, Done, Error
  );
endinterface

// File: rtl/lut_regfile.sv
// DEPTH x TGT_W register table, one write port, one combinational read port.
// Every entry resets asynchronously to all-ones (no target).
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   we_i/waddr_i/wdata_i - write port, applied on the rising edge
//   raddr_i/rdata_o   - combinational read port
module lut_regfile
  import lut_pkg::*;
#(
  parameter int ADDR_W = LUT_ADDR_W,
  parameter int TGT_W  = LUT_TGT_W,
  parameter int DEPTH  = LUT_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [TGT_W-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [TGT_W-1:0]  rdata_o
);

  logic [TGT_W-1:0] mem_q [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        mem_q[gi] <= '1;
      end else if (we_i && (waddr_i == ADDR_W'(gi))) begin
        mem_q[gi] <= wdata_i;
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/branch_lut_writer.sv
// Loader for the programmable branch-target table.
// Accepts a stream of targets (one per cycle) after a Start pulse and
// writes them in index order; a short program is padded with all-ones.
// Ports:
//   Clk, Reset - clock, asynchronous active-high reset
//   bus        - branch_lut_writer_if.slave (stream in, table read, status)
// Optional build macro LUT_WRITE_BYPASS_EN: forwards the value being
// written this cycle to Target when Addr matches the write pointer.
module branch_lut_writer
  import lut_pkg::*;
#(
  parameter int ADDR_W = LUT_ADDR_W,
  parameter int TGT_W  = LUT_TGT_W,
  parameter int DEPTH  = LUT_DEPTH
) (
  input logic                 Clk,
  input logic                 Reset,
  branch_lut_writer_if.slave  bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  lut_wr_state_t     state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              we;
  logic [TGT_W-1:0]  wdata;
  logic [TGT_W-1:0]  rdata;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    done_d  = done_q;
    error_d = error_q;
    we      = 1'b0;
    wdata   = bus.InData;

    unique case (state_q)
      IDLE, READY: begin
        if (bus.Start) begin
          state_d = LOAD;
          ptr_d   = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
        end
      end
      LOAD: begin
        if (bus.InValid) begin
          we = 1'b1;
          // The pointer stops at the last index instead of wrapping.
          if (ptr_q != LAST_IDX) ptr_d = ptr_q + 1'b1;
          if (ptr_q == LAST_IDX) begin
            state_d = READY;
            done_d  = 1'b1;
            error_d = !bus.InLast;  // full table with no InLast: overflow
          end else if (bus.InLast) begin
            state_d = FILL;
          end
        end
      end
      FILL: begin
        we    = 1'b1;
        wdata = '1;
        if (ptr_q == LAST_IDX) begin
          state_d = READY;
          done_d  = 1'b1;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  lut_regfile #(
    .ADDR_W (ADDR_W),
    .TGT_W  (TGT_W),
    .DEPTH  (DEPTH)
  ) u_regfile (
    .clk     (Clk),
    .rst     (Reset),
    .we_i    (we),
    .waddr_i (ptr_q),
    .wdata_i (wdata),
    .raddr_i (bus.Addr),
    .rdata_o (rdata)
  );

`ifdef LUT_WRITE_BYPASS_EN
  // wdata already carries all-ones during FILL, so one compare covers both.
  assign bus.Target = (we && (bus.Addr == ptr_q)) ? wdata : rdata;
`else
  assign bus.Target = rdata;
`endif

  assign bus.InReady = (state_q == LOAD);
  assign bus.Busy    = (state_q == LOAD) || (state_q == FILL);
  assign bus.Done    = done_q;
  assign bus.Error   = error_q;

endmodule

// File: tb/tb_branch_lut_writer.sv
module tb_branch_lut_writer;
  import lut_pkg::*;

  typedef struct {
    logic [3:0] addr;
    logic [8:0] exp_tgt;
  } rd_vec_t;

  typedef struct {
    logic [3:0] idx;
    logic [8:0] data;
  } sb_ent_t;

  logic Clk;
  logic Reset;
  int   n_total;
  int   n_pass;
  int   model_ptr;
  sb_ent_t sb_q[$];
  rd_vec_t vecs[16];

  branch_lut_writer_if #(.ADDR_W(4), .TGT_W(9)) bus ();

  branch_lut_writer dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    model_ptr = 0;
  endtask

  // Present a beat and wait (bounded) until it is accepted.
  task automatic send_beat(input logic [8:0] data, input logic last);
    bit accepted;
    accepted    = 0;
    bus.InValid = 1'b1;
    bus.InData  = data;
    bus.InLast  = last;
    for (int c = 0; c < 20 && !accepted; c++) begin
      #3;
      if (bus.InReady === 1'b1) accepted = 1;
      tick();
    end
    bus.InValid = 1'b0;
    bus.InLast  = 1'b0;
    if (!accepted) check("beat_accept_timeout", 0, 1);
    else begin
      sb_q.push_back('{idx: 4'(model_ptr), data: data});
      $display("beat idx=%0d data=%0h last=%0b", model_ptr, data, last);
      model_ptr++;
    end
  endtask

  task automatic wait_done();
    int c;
    c = 0;
    while (bus.Done !== 1'b1 && c < 50) begin
      tick();
      c++;
    end
    if (c >= 50) check("done_timeout", 0, 1);
  endtask

  // Pop every expected write and compare against the table read port.
  task automatic drain_sb(input string name);
    sb_ent_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      bus.Addr = e.idx;
      #1;
      $display("read %s idx=%0d target=%0h", name, e.idx, bus.Target);
      check(name, bus.Target, e.data);
    end
  endtask

  initial begin
    int busy_cycles;
    n_total = 0;
    n_pass  = 0;
    model_ptr = 0;
    bus.Start = 0; bus.InValid = 0; bus.InData = 0; bus.InLast = 0; bus.Addr = 0;

    // Expected table after the short 3-beat program.
    for (int i = 0; i < 16; i++) vecs[i] = '{addr: 4'(i), exp_tgt: NO_TARGET};
    vecs[0].exp_tgt = 9'd4;
    vecs[1].exp_tgt = 9'd158;
    vecs[2].exp_tgt = 9'd208;

    // Reset state
    Reset = 1'b1;
    tick(); tick();
    check("rst_busy", bus.Busy, 0);
    check("rst_done", bus.Done, 0);
    check("rst_error", bus.Error, 0);
    check("rst_inready", bus.InReady, 0);
    Reset = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      bus.Addr = 4'(i);
      #1;
      check("rst_entry", bus.Target, 9'h1FF);
    end

    // Full 16-beat program, InData = idx*3
    pulse_start();
    check("load_busy", bus.Busy, 1);
    for (int i = 0; i < 16; i++) send_beat(9'(i * 3), i == 15);
    check("full_done", bus.Done, 1);
    check("full_error", bus.Error, 0);
    check("full_busy", bus.Busy, 0);
    drain_sb("full_entry");
    bus.Addr = 4'd5;  #1; check("full_addr5", bus.Target, 9'd15);
    bus.Addr = 4'd15; #1; check("full_addr15", bus.Target, 9'd45);

    // Short 3-beat program followed by 13 fill cycles
    pulse_start();
    check("short_done_cleared", bus.Done, 0);
    busy_cycles = 0;
    send_beat(9'd4, 0);   busy_cycles++;
    send_beat(9'd158, 0); busy_cycles++;
    send_beat(9'd208, 1); busy_cycles++;
    for (int c = 0; c < 40 && bus.Busy === 1'b1; c++) begin
      busy_cycles++;
      tick();
    end
    check("short_busy_cycles", busy_cycles, 16);
    check("short_done", bus.Done, 1);
    check("short_error", bus.Error, 0);
    sb_q.delete();
    for (int i = 0; i < 16; i++) begin
      bus.Addr = vecs[i].addr;
      #1;
      $display("read short idx=%0d target=%0h", vecs[i].addr, bus.Target);
      check("short_entry", bus.Target, vecs[i].exp_tgt);
    end

    // Overflow: 16 beats, no InLast
    pulse_start();
    for (int i = 0; i < 16; i++) send_beat(9'(i + 100), 0);
    check("ovf_error", bus.Error, 1);
    check("ovf_done", bus.Done, 1);
    check("ovf_inready", bus.InReady, 0);
    bus.InValid = 1'b1; bus.InData = 9'h0AA;
    tick(); tick();
    check("ovf_17th_inready", bus.InReady, 0);
    bus.InValid = 1'b0;
    drain_sb("ovf_entry");

    // Stall mid-stream, Start while busy ignored
    pulse_start();
    send_beat(9'd10, 0);
    send_beat(9'd11, 0);
    for (int c = 0; c < 4; c++) tick();
    bus.Addr = 4'd2; #1;
    check("stall_no_write", bus.Target, 9'd102);
    check("stall_busy", bus.Busy, 1);
    bus.Start = 1'b1; tick(); bus.Start = 1'b0;
    check("start_ignored_busy", bus.Busy, 1);
    send_beat(9'd12, 0);
    send_beat(9'd13, 1);
    wait_done();
    check("stall_error", bus.Error, 0);
    drain_sb("stall_entry");
    bus.Addr = 4'd4; #1; check("stall_fill4", bus.Target, 9'h1FF);

    // Reset asserted mid-load
    pulse_start();
    send_beat(9'd55, 0);
    sb_q.delete();
    #2 Reset = 1'b1;
    #1;
    check("midrst_busy", bus.Busy, 0);
    check("midrst_done", bus.Done, 0);
    check("midrst_error", bus.Error, 0);
    for (int i = 0; i < 16; i++) begin
      bus.Addr = 4'(i);
      #1;
      check("midrst_entry", bus.Target, 9'h1FF);
    end
    tick();
    Reset = 1'b0;
    tick();
    check("midrst_idle_inready", bus.InReady, 0);

    // Same-cycle visibility of a write
    pulse_start();
    bus.Addr = 4'd0;
    bus.InValid = 1'b1; bus.InData = 9'h07C; bus.InLast = 1'b0;
    #3;
`ifdef LUT_WRITE_BYPASS_EN
    check("bypass_same_cycle", bus.Target, 9'h07C);
`else
    check("nobypass_same_cycle", bus.Target, 9'h1FF);
`endif
    tick();
    bus.InValid = 1'b0;
    #1;
    check("write_next_cycle", bus.Target, 9'h07C);
    $display("read bypass idx=0 target=%0h", bus.Target);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
